uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000, maximum idle clock cycles allowed between bytes inside a frame; legal range 2 to 2^20-1.
REQ-003 clk_in  input  1  system clock; one clock domain.
REQ-004 rst_in  input  1  reset; synchronous, active-high.
REQ-005 byte_valid_in  input  1  single-cycle strobe: byte_in is valid (driven by uart_rcv valid_out).
REQ-006 byte_in  input  8  received byte (driven by uart_rcv data_out).
REQ-007 cmd_valid_out  output  1  decoded command available.
REQ-008 cmd_ready_in  input  1  downstream accepts the command.
REQ-009 cmd_op_out  output  8  opcode.
REQ-010 cmd_addr_out  output  24  address.
REQ-011 cmd_data_out  output  16  data.
REQ-012 busy_out  output  1  high in any state other than IDLE.
REQ-013 err_csum_out  output  1  one-cycle pulse on a checksum mismatch.
REQ-014 err_timeout_out  output  1  one-cycle pulse on an inter-byte timeout.
REQ-015 err_overrun_out  output  1  one-cycle pulse on a byte dropped in HOLD.
REQ-016 err_count_out  output  8  saturating count of all error pulses.

Function
REQ-017 Frame: SYNC, OP, ADDR[23:16], ADDR[15:8], ADDR[7:0], DATA[15:8], DATA[7:0], CSUM; 8 bytes, big-endian.
REQ-018 Valid CSUM = XOR of the OP, three ADDR and two DATA bytes; SYNC is excluded from CSUM.
REQ-019 States: IDLE, OP, A2, A1, A0, D1, D0, CSUM, HOLD; each accepted byte advances one state, IDLE->OP->A2->A1->A0->D1->D0->CSUM.
REQ-020 IDLE: a byte equal to SYNC_BYTE moves the block to OP; any other byte is discarded silently, with no error.
REQ-021 Bytes are only consumed on cycles with byte_valid_in=1; byte_in is ignored otherwise.
REQ-022 CSUM with a matching byte: outputs latch, cmd_valid_out=1 on the next cycle (1-cycle latency from the CSUM strobe), state HOLD.
REQ-023 CSUM with a mismatching byte: err_csum_out pulses on the next cycle, state IDLE, no command issued.
REQ-024 HOLD: cmd_valid_out and the cmd_* outputs stay stable until a cycle with cmd_ready_in=1; that cycle completes the transfer; cmd_valid_out=0 on the next cycle; state IDLE.
REQ-025 HOLD with byte_valid_in=1 and cmd_ready_in=0: the byte is dropped, err_overrun_out pulses, and the block stays in HOLD.
REQ-026 HOLD with byte_valid_in=1 and cmd_ready_in=1 on the same cycle: handshake completes and the byte is processed as in IDLE (a SYNC byte moves the block to OP).
REQ-027 Timeout counter: cleared on every accepted byte; increments each cycle in states OP..CSUM; when it reaches TIMEOUT_CYCLES-1 with no byte, err_timeout_out pulses and the state goes to IDLE; partial fields are discarded.
REQ-028 The counter is inactive in IDLE and HOLD; HOLD never times out.
REQ-029 A byte arriving on the cycle the timeout would fire is accepted; no timeout occurs.
REQ-030 err_count_out increments by 1 per error pulse and saturates at 8'hFF; error types are mutually exclusive per cycle.
REQ-031 cmd_* outputs are registered; cmd_* values are unchanged while not in HOLD, except when reloaded at CSUM.

Reset
REQ-032 rst_in=1 on a rising edge forces state IDLE, cmd_valid_out=0, cmd_op_out=0, cmd_addr_out=0, cmd_data_out=0, busy_out=0, all err_* pulses=0, err_count_out=0, and timeout counter=0.
REQ-033 Reset in mid-frame or in HOLD abandons the frame or command with no error pulse; the first byte after reset is evaluated in IDLE.

Verification
REQ-034 Bytes A5,01,12,34,56,BE,EF,CSUM where CSUM is the XOR of the six payload bytes (01,12,34,56,BE,EF), cmd_ready_in=1 -> one cycle after the CSUM strobe: cmd_valid_out=1, op=01, addr=123456, data=BEEF; cycle after: valid=0.
REQ-035 Same frame with CSUM byte 00 -> err_csum_out pulse, err_count_out=1, cmd_valid_out never high.
REQ-036 Bytes 00,FF,A5,02, then no byte for TIMEOUT_CYCLES (1000) cycles -> 00 and FF are ignored; err_timeout_out pulses exactly once; busy_out=0 afterwards.
REQ-037 Valid frame with cmd_ready_in=0 for 50 cycles plus an extra byte 33 during HOLD -> err_overrun_out pulse, outputs stable; cmd_ready_in=1 -> valid drops next cycle.
REQ-038 HOLD with cmd_ready_in=1 and byte A5 in the same cycle -> handshake completes and state=OP; a following valid frame is decoded correctly.
REQ-039 rst_in for one cycle after byte A1 of a frame -> all outputs at reset values, no error pulse; a subsequent full frame decodes correctly.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// UART command frame parser: hunts for a sync byte, collects an 8-byte
// big-endian frame, verifies the XOR checksum and holds the decoded command
// until the downstream consumer accepts it.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        byte_valid_in,
  input  logic [7:0]  byte_in,
  output logic        cmd_valid_out,
  input  logic        cmd_ready_in,
  output logic [7:0]  cmd_op_out,
  output logic [23:0] cmd_addr_out,
  output logic [15:0] cmd_data_out,
  output logic        busy_out,
  output logic        err_csum_out,
  output logic        err_timeout_out,
  output logic        err_overrun_out,
  output logic [7:0]  err_count_out
);

  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_OP   = 4'd1,
    S_A2   = 4'd2,
    S_A1   = 4'd3,
    S_A0   = 4'd4,
    S_D1   = 4'd5,
    S_D0   = 4'd6,
    S_CSUM = 4'd7,
    S_HOLD = 4'd8
  } state_t;

  // Running checksum: plain XOR accumulation of the payload bytes.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t      state_q, state_d;
  logic [19:0] tmo_q, tmo_d;
  logic [7:0]  op_q, op_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  csum_q, csum_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_op_q, cmd_op_d;
  logic [23:0] cmd_addr_q, cmd_addr_d;
  logic [15:0] cmd_data_q, cmd_data_d;
  logic        busy_q, busy_d;
  logic        err_csum_q, err_csum_d;
  logic        err_timeout_q, err_timeout_d;
  logic        err_overrun_q, err_overrun_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        in_frame_s;
  logic        tmo_fire_s;

  // Next-state, field capture, timeout and error bookkeeping.
  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    op_d          = op_q;
    addr_d        = addr_q;
    data_d        = data_q;
    csum_d        = csum_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_op_d      = cmd_op_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_data_d    = cmd_data_q;
    err_csum_d    = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    err_count_d   = err_count_q;

    in_frame_s = (state_q != S_IDLE) && (state_q != S_HOLD);
    // A byte on the would-be timeout cycle wins over the timeout.
    tmo_fire_s = in_frame_s && !byte_valid_in && (tmo_q == TMO_LAST);

    // The inter-byte timer only runs while a frame is being collected.
    if (in_frame_s && !byte_valid_in && !tmo_fire_s) begin
      tmo_d = tmo_q + 20'd1;
    end else begin
      tmo_d = 20'd0;
    end

    case (state_q)
      S_IDLE: begin
        if (byte_valid_in && (byte_in == SYNC_BYTE)) begin
          state_d = S_OP;
          csum_d  = 8'h00;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OP, S_A2, S_A1, S_A0, S_D1, S_D0: begin
        if (byte_valid_in) begin
          csum_d = csum_step(csum_q, byte_in);
          case (state_q)
            S_OP:    begin op_d = byte_in;           state_d = S_A2;   end
            S_A2:    begin addr_d[23:16] = byte_in;  state_d = S_A1;   end
            S_A1:    begin addr_d[15:8]  = byte_in;  state_d = S_A0;   end
            S_A0:    begin addr_d[7:0]   = byte_in;  state_d = S_D1;   end
            S_D1:    begin data_d[15:8]  = byte_in;  state_d = S_D0;   end
            S_D0:    begin data_d[7:0]   = byte_in;  state_d = S_CSUM; end
            default: begin state_d = S_IDLE; end
          endcase
        end else if (tmo_fire_s) begin
          state_d       = S_IDLE;
          err_timeout_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_CSUM: begin
        if (byte_valid_in) begin
          if (byte_in == csum_q) begin
            cmd_valid_d = 1'b1;
            cmd_op_d    = op_q;
            cmd_addr_d  = addr_q;
            cmd_data_d  = data_q;
            state_d     = S_HOLD;
          end else begin
            err_csum_d = 1'b1;
            state_d    = S_IDLE;
          end
        end else if (tmo_fire_s) begin
          state_d       = S_IDLE;
          err_timeout_d = 1'b1;
        end else begin
          state_d = S_CSUM;
        end
      end
      S_HOLD: begin
        if (cmd_ready_in) begin
          // Handshake completes; a byte on the same cycle is seen as in IDLE.
          cmd_valid_d = 1'b0;
          if (byte_valid_in && (byte_in == SYNC_BYTE)) begin
            state_d = S_OP;
            csum_d  = 8'h00;
          end else begin
            state_d = S_IDLE;
          end
        end else if (byte_valid_in) begin
          err_overrun_d = 1'b1;
          state_d       = S_HOLD;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((err_csum_d || err_timeout_d || err_overrun_d) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      tmo_q         <= 20'd0;
      op_q          <= 8'h00;
      addr_q        <= 24'h000000;
      data_q        <= 16'h0000;
      csum_q        <= 8'h00;
      cmd_valid_q   <= 1'b0;
      cmd_op_q      <= 8'h00;
      cmd_addr_q    <= 24'h000000;
      cmd_data_q    <= 16'h0000;
      busy_q        <= 1'b0;
      err_csum_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      err_count_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      csum_q        <= csum_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_op_q      <= cmd_op_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_data_q    <= cmd_data_d;
      busy_q        <= busy_d;
      err_csum_q    <= err_csum_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
      err_count_q   <= err_count_d;
    end
  end

  assign cmd_valid_out   = cmd_valid_q;
  assign cmd_op_out      = cmd_op_q;
  assign cmd_addr_out    = cmd_addr_q;
  assign cmd_data_out    = cmd_data_q;
  assign busy_out        = busy_q;
  assign err_csum_out    = err_csum_q;
  assign err_timeout_out = err_timeout_q;
  assign err_overrun_out = err_overrun_q;
  assign err_count_out   = err_count_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a frame-level reference model predicts
// every output each cycle, plus hand-computed literal checks per scenario.
module tb_uart_cmd_parser;

  localparam int T = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bv  = 1'b0;
  logic [7:0]  b   = 8'h00;
  logic        rdy = 1'b1;
  logic        cmd_valid;
  logic [7:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        busy;
  logic        e_csum, e_tmo, e_ovr;
  logic [7:0]  e_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;
  bit done = 1'b0;

  uart_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T)) dut (
    .clk_in(clk), .rst_in(rst), .byte_valid_in(bv), .byte_in(b),
    .cmd_valid_out(cmd_valid), .cmd_ready_in(rdy), .cmd_op_out(cmd_op),
    .cmd_addr_out(cmd_addr), .cmd_data_out(cmd_data), .busy_out(busy),
    .err_csum_out(e_csum), .err_timeout_out(e_tmo), .err_overrun_out(e_ovr),
    .err_count_out(e_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [7:0]  pay[$];
  int          nb = 0;        // bytes of current frame received, 0 = hunting
  int          idle_cnt = 0;
  bit          hold = 1'b0;
  logic        m_valid = 1'b0;
  logic [7:0]  m_op = 8'h00;
  logic [23:0] m_addr = 24'h0;
  logic [15:0] m_data = 16'h0;
  logic        m_ecs = 1'b0, m_eto = 1'b0, m_eov = 1'b0;
  int          m_cnt = 0;

  task automatic model_step();
    logic [7:0] x;
    m_ecs = 1'b0; m_eto = 1'b0; m_eov = 1'b0;
    if (rst) begin
      nb = 0; idle_cnt = 0; hold = 1'b0; m_valid = 1'b0;
      m_op = 8'h00; m_addr = 24'h0; m_data = 16'h0; m_cnt = 0;
      pay.delete();
      return;
    end
    if (hold) begin
      if (rdy) begin
        hold = 1'b0; m_valid = 1'b0;
        if (bv && b == 8'hA5) begin nb = 1; idle_cnt = 0; pay.delete(); end
      end else if (bv) begin
        m_eov = 1'b1;
      end
    end else if (nb == 0) begin
      if (bv && b == 8'hA5) begin nb = 1; idle_cnt = 0; pay.delete(); end
    end else if (bv) begin
      idle_cnt = 0;
      if (nb < 7) begin
        pay.push_back(b); nb++;
      end else begin
        x = 8'h00;
        foreach (pay[i]) x = x ^ pay[i];
        if (x == b) begin
          hold = 1'b1; m_valid = 1'b1; m_op = pay[0];
          m_addr = {pay[1], pay[2], pay[3]}; m_data = {pay[4], pay[5]};
        end else begin
          m_ecs = 1'b1;
        end
        nb = 0;
      end
    end else begin
      idle_cnt++;
      if (idle_cnt == T) begin m_eto = 1'b1; nb = 0; end
    end
    if ((m_ecs || m_eto || m_eov) && m_cnt < 255) m_cnt++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      started = 1'b1;
    end
  end

  // Compare every DUT output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started && !done) begin
        chk("valid", 32'(cmd_valid), 32'(m_valid));
        chk("op", 32'(cmd_op), 32'(m_op));
        chk("addr", 32'(cmd_addr), 32'(m_addr));
        chk("data", 32'(cmd_data), 32'(m_data));
        chk("busy", 32'(busy), 32'(hold || nb != 0));
        chk("err_csum", 32'(e_csum), 32'(m_ecs));
        chk("err_timeout", 32'(e_tmo), 32'(m_eto));
        chk("err_overrun", 32'(e_ovr), 32'(m_eov));
        chk("err_count", 32'(e_cnt), 32'(m_cnt));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] v);
    bv = 1'b1; b = v; cyc(); bv = 1'b0; b = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [23:0] a,
                            input logic [15:0] d, input logic [7:0] cs);
    send(8'hA5); send(op); send(a[23:16]); send(a[15:8]); send(a[7:0]);
    send(d[15:8]); send(d[7:0]); send(cs);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  int n;

  initial begin
    cyc(); cyc(); rst = 1'b0;
    // reset state
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(e_cnt), 32'd0);

    // good frame, checksum 01^12^34^56^BE^EF = 20
    rdy = 1'b1;
    send_frame(8'h01, 24'h123456, 16'hBEEF, 8'h20);
    chk("f1_valid", 32'(cmd_valid), 32'd1);
    chk("f1_op", 32'(cmd_op), 32'h01);
    chk("f1_addr", 32'(cmd_addr), 32'h123456);
    chk("f1_data", 32'(cmd_data), 32'hBEEF);
    cyc();
    chk("f1_drop", 32'(cmd_valid), 32'd0);

    // bad checksum
    do_reset();
    send_frame(8'h01, 24'h123456, 16'hBEEF, 8'h00);
    chk("cs_pulse", 32'(e_csum), 32'd1);
    chk("cs_count", 32'(e_cnt), 32'd1);
    chk("cs_valid", 32'(cmd_valid), 32'd0);

    // junk ignored, then timeout after a partial frame
    send(8'h00); send(8'hFF);
    chk("junk_busy", 32'(busy), 32'd0);
    send(8'hA5); send(8'h02);
    n = 0;
    for (int i = 0; i < T + 10; i++) begin
      cyc();
      if (e_tmo) n++;
    end
    chk("tmo_pulses", 32'(n), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_count", 32'(e_cnt), 32'd2);

    // byte on the would-be timeout cycle is accepted (07^01^02 = 04)
    send(8'hA5);
    repeat (T - 1) cyc();
    send(8'h07);
    chk("tmo_edge_busy", 32'(busy), 32'd1);
    chk("tmo_edge_noerr", 32'(e_tmo), 32'd0);
    send(8'h00); send(8'h00); send(8'h01); send(8'h00); send(8'h02); send(8'h04);
    chk("tmo_edge_valid", 32'(cmd_valid), 32'd1);
    chk("tmo_edge_op", 32'(cmd_op), 32'h07);
    cyc();

    // held command, overrun, then release
    rdy = 1'b0;
    send_frame(8'h01, 24'h123456, 16'hBEEF, 8'h20);
    repeat (20) cyc();
    send(8'h33);
    chk("ovr_pulse", 32'(e_ovr), 32'd1);
    repeat (29) cyc();
    chk("ovr_valid", 32'(cmd_valid), 32'd1);
    chk("ovr_addr", 32'(cmd_addr), 32'h123456);
    rdy = 1'b1; cyc();
    chk("ovr_release", 32'(cmd_valid), 32'd0);

    // release and sync on the same cycle (02^AB^CD^EF^12^34 = AD)
    rdy = 1'b0;
    send_frame(8'h01, 24'h123456, 16'hBEEF, 8'h20);
    repeat (3) cyc();
    rdy = 1'b1;
    send(8'hA5);
    chk("hs_valid", 32'(cmd_valid), 32'd0);
    chk("hs_busy", 32'(busy), 32'd1);
    send(8'h02); send(8'hAB); send(8'hCD); send(8'hEF); send(8'h12); send(8'h34); send(8'hAD);
    chk("hs_valid2", 32'(cmd_valid), 32'd1);
    chk("hs_addr", 32'(cmd_addr), 32'hABCDEF);
    chk("hs_data", 32'(cmd_data), 32'h1234);
    cyc();

    // reset mid-frame
    send(8'hA5); send(8'h01); send(8'h12); send(8'h34);
    do_reset();
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_op", 32'(cmd_op), 32'h00);
    chk("mr_count", 32'(e_cnt), 32'd0);
    send_frame(8'h01, 24'h123456, 16'hBEEF, 8'h20);
    chk("mr_valid", 32'(cmd_valid), 32'd1);
    chk("mr_data", 32'(cmd_data), 32'hBEEF);
    cyc();

    // error counter saturation via repeated overruns
    rdy = 1'b0;
    send_frame(8'h01, 24'h123456, 16'hBEEF, 8'h20);
    bv = 1'b1; b = 8'h33;
    repeat (300) cyc();
    bv = 1'b0;
    chk("sat_count", 32'(e_cnt), 32'hFF);
    chk("sat_valid", 32'(cmd_valid), 32'd1);
    rdy = 1'b1; cyc(); cyc();
    chk("sat_release", 32'(cmd_valid), 32'd0);

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
